// File: rtl/fifo_rd_word_packer.sv
// fifo_rd_word_packer: packs FIFO bytes little-endian into words on a valid/ready port; optional idle auto-flush under PACK_TIMEOUT_EN
module fifo_rd_word_packer #(
    parameter int DATA_W         = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                 rdClk,
    input  logic                                 rdRst,
    input  logic                                 fifoEmpty,
    input  logic [DATA_W-1:0]                    rdData,
    output logic                                 rdEn,
    input  logic                                 flush,
    output logic [DATA_W*BYTES_PER_WORD-1:0]     wordData,
    output logic [$clog2(BYTES_PER_WORD):0]      wordBytes,
    output logic                                 wordValid,
    input  logic                                 wordReady
);
    localparam int CW = $clog2(BYTES_PER_WORD) + 1;

    typedef enum logic {FILL, HOLD} state_t;

    state_t        state;
    logic [CW-1:0] byteCnt;
    logic          inFlight;
    logic          flushPend;
    logic          flushReq;
    logic          timeoutHit;

    // Pop only while filling, with room for the byte and no flush draining.
    assign rdEn = !rdRst && state == FILL && !fifoEmpty && !flushPend &&
                  ((byteCnt + CW'(inFlight)) < CW'(BYTES_PER_WORD));

    // A flush only matters when there is something to emit.
    assign flushReq = state == FILL && (flush || timeoutHit) && (|byteCnt || inFlight);

`ifdef PACK_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    logic [IW-1:0] idleCnt;

    assign timeoutHit = idleCnt == IW'(TIMEOUT_CYCLES);

    // Counts idle cycles with a partial word parked and nothing arriving.
    always_ff @(posedge rdClk) begin
        if (rdRst || inFlight || (state == HOLD && wordReady))
            idleCnt <= '0;
        else if (state == FILL && |byteCnt && !rdEn)
            idleCnt <= idleCnt + IW'(1);
    end
`else
    assign timeoutHit = TIMEOUT_CYCLES < 0;
`endif

    // Lane capture, word completion, flush draining and output handshake.
    always_ff @(posedge rdClk) begin
        if (rdRst) begin
            state     <= FILL;
            byteCnt   <= '0;
            inFlight  <= 1'b0;
            flushPend <= 1'b0;
            wordValid <= 1'b0;
            wordData  <= '0;
            wordBytes <= '0;
        end else if (state == FILL) begin
            inFlight <= rdEn;
            if (inFlight) begin
                wordData[byteCnt*DATA_W +: DATA_W] <= rdData;
                byteCnt <= byteCnt + CW'(1);
            end
            if (inFlight && byteCnt == CW'(BYTES_PER_WORD - 1)) begin
                state     <= HOLD;
                wordValid <= 1'b1;
                wordBytes <= CW'(BYTES_PER_WORD);
            end else if (!inFlight && (flushPend || (flushReq && !rdEn))) begin
                state     <= HOLD;
                wordValid <= 1'b1;
                wordBytes <= byteCnt;
            end else if (flushReq) begin
                flushPend <= 1'b1;
            end
        end else if (wordReady) begin
            state     <= FILL;
            wordValid <= 1'b0;
            byteCnt   <= '0;
            wordData  <= '0;
            wordBytes <= '0;
            flushPend <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fifo_rd_word_packer.sv
// tb_fifo_rd_word_packer: directed scenarios plus randomized traffic against a byte-stream model
module tb_fifo_rd_word_packer;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifoEmpty = 1'b1;
    logic [7:0]  rdData = '0;
    logic        rdEn;
    logic        flush = 1'b0;
    logic [31:0] wordData;
    logic [2:0]  wordBytes;
    logic        wordValid;
    logic        wordReady = 1'b0;

    logic [7:0]  fifoQ[$];
    int          total = 0;
    int          bad = 0;

    fifo_rd_word_packer #(.DATA_W(8), .BYTES_PER_WORD(4), .TIMEOUT_CYCLES(TO)) dut (
        .rdClk(clk), .rdRst(rst), .fifoEmpty(fifoEmpty), .rdData(rdData), .rdEn(rdEn),
        .flush(flush), .wordData(wordData), .wordBytes(wordBytes), .wordValid(wordValid),
        .wordReady(wordReady)
    );

    always #5 clk = ~clk;

    // FIFO model: data appears the cycle after an accepted pop.
    always @(posedge clk) begin
        if (rdEn && !fifoEmpty) begin
            rdData    <= fifoQ.pop_front();
            fifoEmpty <= (fifoQ.size() == 0);
        end
    end

    task automatic pushByte(input logic [7:0] b);
        fifoQ.push_back(b);
        fifoEmpty = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        flush = 1'b0;
        wordReady = 1'b0;
        fifoQ.delete();
        fifoEmpty = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        pushByte(8'h5A);
        #1;
        total++; if (rdEn !== 1'b0) begin bad++; $display("FAIL reset_rdEn got=%b exp=0", rdEn); end
        @(negedge clk); #1;
        total++; if (wordValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", wordValid); end
        total++; if (wordData !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", wordData); end
        total++; if (wordBytes !== 3'd0) begin bad++; $display("FAIL reset_bytes got=%0d exp=0", wordBytes); end
        fifoQ.delete();
        fifoEmpty = 1'b1;
        rst = 1'b0;
    endtask

    task automatic test_full_word();
        int pops = 0, valids = 0;
        logic [31:0] gotData = '0;
        logic [2:0] gotBytes = '0;
        doReset();
        pushByte(8'hAA); pushByte(8'hBB); pushByte(8'hCC); pushByte(8'hDD);
        wordReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (rdEn && !fifoEmpty) pops++;
            if (wordValid) begin valids++; gotData = wordData; gotBytes = wordBytes; end
            @(negedge clk);
        end
        wordReady = 1'b0;
        total++; if (gotData !== 32'hDDCCBBAA) begin bad++; $display("FAIL full_data got=%h exp=ddccbbaa", gotData); end
        total++; if (gotBytes !== 3'd4) begin bad++; $display("FAIL full_bytes got=%0d exp=4", gotBytes); end
        total++; if (valids != 1) begin bad++; $display("FAIL full_valid_cycles got=%0d exp=1", valids); end
        total++; if (pops != 4) begin bad++; $display("FAIL full_pops got=%0d exp=4", pops); end
    endtask

    task automatic test_back_to_back();
        int w = 0;
        doReset();
        pushByte(8'hAA); pushByte(8'hBB); pushByte(8'hCC); pushByte(8'hDD); pushByte(8'hEE);
        while (w < 20) begin #1; if (wordValid) break; @(negedge clk); w++; end
        total++; if (w >= 20) begin bad++; $display("FAIL bp_wait got=timeout exp=wordValid"); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            total++;
            if (wordValid !== 1'b1 || wordData !== 32'hDDCCBBAA || rdEn !== 1'b0 || fifoQ.size() != 1) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got v=%b d=%h rdEn=%b q=%0d exp v=1 d=ddccbbaa rdEn=0 q=1",
                         i, wordValid, wordData, rdEn, fifoQ.size());
            end
        end
        @(negedge clk); wordReady = 1'b1;
        @(negedge clk); wordReady = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        total++; if (fifoQ.size() != 0) begin bad++; $display("FAIL bp_ee_pop got=%0d exp=0", fifoQ.size()); end
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        w = 0;
        while (w < 10) begin #1; if (wordValid) break; @(negedge clk); w++; end
        total++; if (wordData !== 32'h000000EE || wordBytes !== 3'd1) begin
            bad++; $display("FAIL bp_ee_word got=%h/%0d exp=000000ee/1", wordData, wordBytes);
        end
    endtask

    task automatic test_flush_partial();
        int w = 0;
        doReset();
        pushByte(8'hAA); pushByte(8'hBB); pushByte(8'hCC);
        repeat (6) @(negedge clk);
        #1;
        total++; if (wordValid !== 1'b0) begin bad++; $display("FAIL flush_pre got=%b exp=0", wordValid); end
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        while (w < 10) begin #1; if (wordValid) break; @(negedge clk); w++; end
        total++; if (wordData !== 32'h00CCBBAA) begin bad++; $display("FAIL flush_data got=%h exp=00ccbbaa", wordData); end
        total++; if (wordBytes !== 3'd3) begin bad++; $display("FAIL flush_bytes got=%0d exp=3", wordBytes); end
        @(negedge clk); wordReady = 1'b1;
        @(negedge clk); wordReady = 1'b0; #1;
        total++; if (wordValid !== 1'b0) begin bad++; $display("FAIL flush_drain got=%b exp=0", wordValid); end
    endtask

    task automatic test_idle_flush();
        int seen = 0;
        doReset();
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        for (int i = 0; i < 20; i++) begin #1; if (wordValid) seen++; @(negedge clk); end
        total++; if (seen != 0) begin bad++; $display("FAIL idle_flush got=%0d valid cycles exp=0", seen); end
    endtask

    task automatic test_reset_mid();
        int w = 0;
        doReset();
        pushByte(8'hAA); pushByte(8'hBB);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (rdEn !== 1'b0) begin bad++; $display("FAIL midrst_rdEn got=%b exp=0", rdEn); end
        @(negedge clk); rst = 1'b0; #1;
        total++; if (wordValid !== 1'b0 || wordData !== 32'h0 || wordBytes !== 3'd0) begin
            bad++; $display("FAIL midrst_out got=%b/%h/%0d exp=0/0/0", wordValid, wordData, wordBytes);
        end
        @(negedge clk);
        pushByte(8'h11); pushByte(8'h22); pushByte(8'h33); pushByte(8'h44);
        wordReady = 1'b1;
        while (w < 20) begin #1; if (wordValid) break; @(negedge clk); w++; end
        total++; if (wordData !== 32'h44332211 || wordBytes !== 3'd4) begin
            bad++; $display("FAIL midrst_word got=%h/%0d exp=44332211/4", wordData, wordBytes);
        end
        @(negedge clk); wordReady = 1'b0;
    endtask

    task automatic test_timeout();
        int w = 0, c = 0;
        doReset();
        pushByte(8'h11);
        wordReady = 1'b0;
        while (w < 10) begin #1; if (rdEn && !fifoEmpty) break; @(negedge clk); w++; end
        total++; if (w >= 10) begin bad++; $display("FAIL to_pop got=timeout exp=pop"); end
`ifdef PACK_TIMEOUT_EN
        while (c < TO + 10) begin @(negedge clk); c++; #1; if (wordValid) break; end
        total++; if (!wordValid || c > TO + 3) begin
            bad++; $display("FAIL to_latency got=%0d cycles valid=%b exp<=%0d", c, wordValid, TO + 3);
        end
        total++; if (wordData !== 32'h00000011 || wordBytes !== 3'd1) begin
            bad++; $display("FAIL to_word got=%h/%0d exp=00000011/1", wordData, wordBytes);
        end
`else
        for (int i = 0; i < 100; i++) begin @(negedge clk); #1; if (wordValid) c++; end
        total++; if (c != 0) begin bad++; $display("FAIL to_none got=%0d valid cycles exp=0", c); end
`endif
    endtask

    task automatic test_random();
        logic [7:0] expQ[$];
        logic [7:0] b;
        logic [31:0] exp;
        int pushed = 0, words = 0, illegal = 0;
        doReset();
        for (int cyc = 0; cyc < 3000 && words < 16; cyc++) begin
            if (pushed < 64 && $urandom_range(2) != 0) begin
                b = 8'($urandom);
                pushByte(b);
                expQ.push_back(b);
                pushed++;
            end
            wordReady = 1'($urandom_range(1));
            #1;
            if (rdEn && fifoEmpty) illegal++;
            if (wordValid && wordReady) begin
                exp = '0;
                for (int k = 0; k < 4; k++) if (expQ.size() > 0) exp |= 32'(expQ.pop_front()) << (8 * k);
                total++;
                if (wordData !== exp || wordBytes !== 3'd4) begin
                    bad++; $display("FAIL rand_word n=%0d got=%h/%0d exp=%h/4", words, wordData, wordBytes, exp);
                end
                words++;
            end
            @(negedge clk);
        end
        wordReady = 1'b0;
        total++; if (words != 16) begin bad++; $display("FAIL rand_count got=%0d exp=16", words); end
        total++; if (illegal != 0) begin bad++; $display("FAIL rand_empty_pop got=%0d exp=0", illegal); end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_back_to_back();
        test_flush_partial();
        test_idle_flush();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
